// File: rtl/m6809_core_pkg.sv
// Shared 6809 core constants: 16-bit sequencer op codes, 8-bit ALU nibble encodings,
// sequencer state encoding and the packed {h,n,z,v,c} flag bundle.
package m6809_core_pkg;

  localparam logic [2:0] ALU16_ADD = 3'd0;
  localparam logic [2:0] ALU16_SUB = 3'd1;
  localparam logic [2:0] ALU16_CMP = 3'd2;
  localparam logic [2:0] ALU16_LD  = 3'd3;
  localparam logic [2:0] ALU16_ST  = 3'd4;

  // Accumulator-class ops (opcode bit 7 set): native low-nibble encoding
  localparam logic [3:0] ALU_OP_SUB = 4'h0;
  localparam logic [3:0] ALU_OP_CMP = 4'h1;
  localparam logic [3:0] ALU_OP_SBC = 4'h2;
  localparam logic [3:0] ALU_OP_AND = 4'h4;
  localparam logic [3:0] ALU_OP_BIT = 4'h5;
  localparam logic [3:0] ALU_OP_LD  = 4'h6;
  localparam logic [3:0] ALU_OP_ST  = 4'h7;
  localparam logic [3:0] ALU_OP_EOR = 4'h8;
  localparam logic [3:0] ALU_OP_ADC = 4'h9;
  localparam logic [3:0] ALU_OP_OR  = 4'hA;
  localparam logic [3:0] ALU_OP_ADD = 4'hB;

  // Read-modify-write / inherent ops (opcode bit 7 clear)
  localparam logic [3:0] RMW_NEG = 4'h0;
  localparam logic [3:0] RMW_COM = 4'h3;
  localparam logic [3:0] RMW_LSR = 4'h4;
  localparam logic [3:0] RMW_ROR = 4'h6;
  localparam logic [3:0] RMW_ASR = 4'h7;
  localparam logic [3:0] RMW_ASL = 4'h8;
  localparam logic [3:0] RMW_ROL = 4'h9;
  localparam logic [3:0] RMW_DEC = 4'hA;
  localparam logic [3:0] RMW_INC = 4'hC;
  localparam logic [3:0] RMW_TST = 4'hD;
  localparam logic [3:0] RMW_CLR = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic h;
    logic n;
    logic z;
    logic v;
    logic c;
  } cc5_t;

  // CMP, BIT and ST only set flags; everything else writes its result back
  function automatic logic op8_writes_back(input logic [3:0] op, input logic op7);
    return !((op == ALU_OP_CMP) || (op == ALU_OP_BIT) || ((op == ALU_OP_ST) && op7));
  endfunction

endpackage

// File: rtl/m6809_core_alu8.sv
// Combinational 6809 8-bit ALU. SBC takes its carry-in as not-borrow (adder style);
// subtract carry-out is reported 6809 style, i.e. C=1 means a borrow occurred.
module m6809_core_alu8
  import m6809_core_pkg::*;
(
  input  logic       i_val_clock,
  input  logic [3:0] i_op,
  input  logic       i_op7,
  input  logic [7:0] i_in_a,
  input  logic [7:0] i_in_b,
  input  logic       i_c_in,
  input  logic       i_v_in,
  input  logic       i_h_in,
  output logic [7:0] o_out,
  output cc5_t       o_flags
);

  logic       w_is_sub;
  logic [7:0] w_opb;
  logic       w_cy;
  logic [8:0] w_sum;
  logic [7:0] w_res;
  cc5_t       w_fl;

  always_comb begin
    w_is_sub = 1'b0;
    w_cy     = 1'b0;
    if (i_op7) begin
      case (i_op)
        ALU_OP_SUB, ALU_OP_CMP: begin w_is_sub = 1'b1; w_cy = 1'b1;   end
        ALU_OP_SBC:             begin w_is_sub = 1'b1; w_cy = i_c_in; end
        ALU_OP_ADC:             w_cy = i_c_in;
        default:                ;
      endcase
    end
  end

  assign w_opb = w_is_sub ? ~i_in_b : i_in_b;
  assign w_sum = {1'b0, i_in_a} + {1'b0, w_opb} + {8'd0, w_cy};

  always_comb begin
    w_res = i_in_a;
    w_fl  = '{h: i_h_in, n: 1'b0, z: 1'b0, v: i_v_in, c: i_c_in};
    if (i_op7) begin
      case (i_op)
        ALU_OP_SUB, ALU_OP_CMP, ALU_OP_SBC: begin
          w_res  = w_sum[7:0];
          w_fl.c = ~w_sum[8];
          w_fl.v = (i_in_a[7] != i_in_b[7]) && (w_sum[7] != i_in_a[7]);
        end
        ALU_OP_ADD, ALU_OP_ADC: begin
          w_res  = w_sum[7:0];
          w_fl.c = w_sum[8];
          w_fl.v = (i_in_a[7] == i_in_b[7]) && (w_sum[7] != i_in_a[7]);
          w_fl.h = i_in_a[4] ^ i_in_b[4] ^ w_sum[4];
        end
        ALU_OP_AND, ALU_OP_BIT: begin w_res = i_in_a & i_in_b; w_fl.v = 1'b0; end
        ALU_OP_LD:              begin w_res = i_in_b;          w_fl.v = 1'b0; end
        ALU_OP_ST:              begin w_res = i_in_a;          w_fl.v = 1'b0; end
        ALU_OP_EOR:             begin w_res = i_in_a ^ i_in_b; w_fl.v = 1'b0; end
        ALU_OP_OR:              begin w_res = i_in_a | i_in_b; w_fl.v = 1'b0; end
        default:                ;
      endcase
    end else begin
      case (i_op)
        RMW_NEG: begin
          w_res  = 8'd0 - i_in_a;
          w_fl.c = |i_in_a;
          w_fl.v = (i_in_a == 8'h80);
        end
        RMW_COM: begin w_res = ~i_in_a; w_fl.v = 1'b0; w_fl.c = 1'b1; end
        RMW_LSR: begin w_res = {1'b0, i_in_a[7:1]};      w_fl.c = i_in_a[0]; end
        RMW_ROR: begin w_res = {i_c_in, i_in_a[7:1]};    w_fl.c = i_in_a[0]; end
        RMW_ASR: begin w_res = {i_in_a[7], i_in_a[7:1]}; w_fl.c = i_in_a[0]; end
        RMW_ASL: begin
          w_res  = {i_in_a[6:0], 1'b0};
          w_fl.c = i_in_a[7];
          w_fl.v = i_in_a[7] ^ i_in_a[6];
        end
        RMW_ROL: begin
          w_res  = {i_in_a[6:0], i_c_in};
          w_fl.c = i_in_a[7];
          w_fl.v = i_in_a[7] ^ i_in_a[6];
        end
        RMW_DEC: begin w_res = i_in_a - 8'd1; w_fl.v = (i_in_a == 8'h80); end
        RMW_INC: begin w_res = i_in_a + 8'd1; w_fl.v = (i_in_a == 8'h7F); end
        RMW_TST: w_fl.v = 1'b0;
        RMW_CLR: begin w_res = 8'd0; w_fl.v = 1'b0; w_fl.c = 1'b0; end
        default: ;
      endcase
    end
    w_fl.n = w_res[7];
    w_fl.z = (w_res == 8'd0);
  end

  assign o_out   = w_res;
  assign o_flags = w_fl;

  ap_op_known: assert property (@(posedge i_val_clock) !$isunknown({i_op7, i_op, i_c_in}));

endmodule

// File: rtl/m6809_core_alu16_seq.sv
// Runs 16-bit D-register ops as two chained byte passes (low, then high) through the
// shared 8-bit ALU, and single 8-bit ops as one pass; owns the ALU while busy.
module m6809_core_alu16_seq
  import m6809_core_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_wide,
  input  logic [2:0]  i_op16,
  input  logic [3:0]  i_op8,
  input  logic        i_op8_7,
  input  logic [15:0] i_a16,
  input  logic [15:0] i_b16,
  input  logic [2:0]  i_cc_in,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_wb,
  output logic [15:0] o_result,
  output logic [4:0]  o_cc_out
);

  seq_state_e  r_state;
  logic        r_wide;
  logic [2:0]  r_op16;
  logic [3:0]  r_op8;
  logic        r_op8_7;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [2:0]  r_cc;      // {h,v,c}
  logic [7:0]  r_lo;
  logic        r_c_lo;
  logic        r_z_lo;
  logic [15:0] r_result;
  cc5_t        r_cc_out;
  logic        r_wb;

  logic [3:0]  w_alu_op;
  logic        w_alu_op7;
  logic [7:0]  w_alu_a;
  logic [7:0]  w_alu_b;
  logic        w_alu_cin;
  logic        w_alu_vin;
  logic        w_alu_hin;
  logic [7:0]  w_alu_out;
  cc5_t        w_alu_fl;

  logic [15:0] w_res16;
  cc5_t        w_cc16;
  logic        w_wb16;

  // ALU lines stay quiet outside the two pass states
  always_comb begin
    w_alu_op  = 4'd0;
    w_alu_op7 = 1'b0;
    w_alu_a   = 8'd0;
    w_alu_b   = 8'd0;
    w_alu_cin = 1'b0;
    w_alu_vin = 1'b0;
    w_alu_hin = 1'b0;
    case (r_state)
      ST_LO: begin
        w_alu_a   = r_a[7:0];
        w_alu_b   = r_b[7:0];
        w_alu_cin = r_cc[0];
        w_alu_vin = r_cc[1];
        w_alu_hin = r_cc[2];
        if (r_wide) begin
          w_alu_op7 = 1'b1;
          case (r_op16)
            ALU16_ADD:            w_alu_op = ALU_OP_ADD;
            ALU16_SUB, ALU16_CMP: w_alu_op = ALU_OP_SUB;
            default:              w_alu_op = ALU_OP_LD;
          endcase
        end else begin
          w_alu_op  = r_op8;
          w_alu_op7 = r_op8_7;
        end
      end
      ST_HI: begin
        w_alu_a   = r_a[15:8];
        w_alu_b   = r_b[15:8];
        w_alu_op7 = 1'b1;
        w_alu_vin = r_cc[1];
        w_alu_hin = r_cc[2];
        case (r_op16)
          ALU16_ADD: begin w_alu_op = ALU_OP_ADC; w_alu_cin = r_c_lo;  end
          ALU16_SUB, ALU16_CMP: begin
            w_alu_op  = ALU_OP_SBC;
            w_alu_cin = ~r_c_lo;  // low pass reported borrow; SBC wants not-borrow
          end
          default:   begin w_alu_op = ALU_OP_LD;  w_alu_cin = r_cc[0]; end
        endcase
      end
      default: ;
    endcase
  end

  m6809_core_alu8 u_alu8 (
    .i_val_clock (i_clk),
    .i_op        (w_alu_op),
    .i_op7       (w_alu_op7),
    .i_in_a      (w_alu_a),
    .i_in_b      (w_alu_b),
    .i_c_in      (w_alu_cin),
    .i_v_in      (w_alu_vin),
    .i_h_in      (w_alu_hin),
    .o_out       (w_alu_out),
    .o_flags     (w_alu_fl)
  );

  // Word flags come from the full operands, not from the high-byte ALU flags
  assign w_res16 = {w_alu_out, r_lo};

  always_comb begin
    w_cc16.h = r_cc[2];
    w_cc16.n = w_res16[15];
    w_cc16.z = r_z_lo && (w_alu_out == 8'd0);
    w_cc16.v = 1'b0;
    w_cc16.c = r_cc[0];
    w_wb16   = 1'b0;
    case (r_op16)
      ALU16_ADD: begin
        w_cc16.c = (r_a > ~r_b);  // a+b overflows 16 bits exactly when a > 0xFFFF-b
        w_cc16.v = (r_a[15] == r_b[15]) && (w_res16[15] != r_a[15]);
        w_wb16   = 1'b1;
      end
      ALU16_SUB, ALU16_CMP: begin
        w_cc16.c = (r_a < r_b);
        w_cc16.v = (r_a[15] != r_b[15]) && (w_res16[15] != r_a[15]);
        w_wb16   = (r_op16 == ALU16_SUB);
      end
      ALU16_LD: w_wb16 = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_wide   <= 1'b0;
      r_op16   <= 3'd0;
      r_op8    <= 4'd0;
      r_op8_7  <= 1'b0;
      r_a      <= 16'd0;
      r_b      <= 16'd0;
      r_cc     <= 3'd0;
      r_lo     <= 8'd0;
      r_c_lo   <= 1'b0;
      r_z_lo   <= 1'b0;
      r_result <= 16'd0;
      r_cc_out <= '0;
      r_wb     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_wide  <= i_wide;
            r_op16  <= i_op16;
            r_op8   <= i_op8;
            r_op8_7 <= i_op8_7;
            r_a     <= i_a16;
            r_b     <= i_b16;
            r_cc    <= i_cc_in;
            r_state <= ST_LO;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LO: begin
          r_lo   <= w_alu_out;
          r_c_lo <= w_alu_fl.c;
          r_z_lo <= w_alu_fl.z;
          if (r_wide) begin
            r_state <= ST_HI;
          end else begin
            r_state  <= ST_DONE;
            r_result <= {r_a[15:8], w_alu_out};
            r_cc_out <= w_alu_fl;
            r_wb     <= op8_writes_back(r_op8, r_op8_7);
          end
        end
        ST_HI: begin
          r_state  <= ST_DONE;
          r_result <= w_res16;
          r_cc_out <= w_cc16;
          r_wb     <= w_wb16;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign o_busy   = (r_state == ST_LO) || (r_state == ST_HI);
  assign o_done   = (r_state == ST_DONE);
  assign o_wb     = r_wb;
  assign o_result = r_result;
  assign o_cc_out = r_cc_out;

endmodule

// File: tb/tb_m6809_core_alu16_seq.sv
// Directed bench for the 16/8-bit ALU sequencer: hand-computed vectors, latency,
// back-to-back issue, busy-time start rejection and mid-op reset.
module tb_m6809_core_alu16_seq;
  import m6809_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        wide = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [3:0]  op8 = 4'd0;
  logic        op8_7 = 1'b0;
  logic [15:0] a16 = 16'd0;
  logic [15:0] b16 = 16'd0;
  logic [2:0]  cc_in = 3'd0;
  logic        ready, busy, done, wb;
  logic [15:0] result;
  logic [4:0]  cc_out;

  int checks = 0;
  int failures = 0;
  int lat;
  logic [8:0] dmask, bmask;

  always #5 clk = ~clk;

  m6809_core_alu16_seq dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_start   (start),
    .i_wide    (wide),
    .i_op16    (op16),
    .i_op8     (op8),
    .i_op8_7   (op8_7),
    .i_a16     (a16),
    .i_b16     (b16),
    .i_cc_in   (cc_in),
    .o_ready   (ready),
    .o_busy    (busy),
    .o_done    (done),
    .o_wb      (wb),
    .o_result  (result),
    .o_cc_out  (cc_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op and return the number of negedges until done (0 if it never came)
  task automatic run_op(input logic w, input logic [2:0] o16, input logic [3:0] o8,
                        input logic o7, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] cc, output int l);
    @(negedge clk);
    wide = w; op16 = o16; op8 = o8; op8_7 = o7; a16 = a; b16 = b; cc_in = cc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    l = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) begin l = i; break; end
    end
  endtask

  task automatic op_chk(input string tag, input int l, input int el, input logic [15:0] er,
                        input logic [4:0] ecc, input logic ewb);
    chk({tag, ".lat"}, l, el);
    chk({tag, ".res"}, result, er);
    chk({tag, ".cc"}, cc_out, ecc);
    chk({tag, ".wb"}, wb, ewb);
  endtask

  initial begin
    #2;
    chk("rst.ready", ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.wb", wb, 0);
    chk("rst.res", result, 0);
    chk("rst.cc", cc_out, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // cc_out = {h,n,z,v,c}
    run_op(1, ALU16_ADD, 0, 0, 16'h12FF, 16'h0001, 3'b000, lat);
    op_chk("add", lat, 3, 16'h1300, 5'b00000, 1);
    chk("add.ready_in_done", ready, 1);
    run_op(1, ALU16_ADD, 0, 0, 16'hFFFF, 16'h0001, 3'b000, lat);
    op_chk("add_wrap", lat, 3, 16'h0000, 5'b00101, 1);
    run_op(1, ALU16_ADD, 0, 0, 16'h7FFF, 16'h0001, 3'b000, lat);
    op_chk("add_ovf", lat, 3, 16'h8000, 5'b01010, 1);
    run_op(1, ALU16_SUB, 0, 0, 16'h1000, 16'h0001, 3'b000, lat);
    op_chk("sub_borrow_lo", lat, 3, 16'h0FFF, 5'b00000, 1);
    run_op(1, ALU16_SUB, 0, 0, 16'h0000, 16'h0001, 3'b000, lat);
    op_chk("sub_under", lat, 3, 16'hFFFF, 5'b01001, 1);
    run_op(1, ALU16_CMP, 0, 0, 16'h0000, 16'h0001, 3'b000, lat);
    op_chk("cmp", lat, 3, 16'hFFFF, 5'b01001, 0);
    run_op(1, ALU16_LD, 0, 0, 16'h1234, 16'h8000, 3'b111, lat);
    op_chk("ld", lat, 3, 16'h8000, 5'b11001, 1);
    run_op(1, ALU16_ST, 0, 0, 16'h5555, 16'h0000, 3'b000, lat);
    op_chk("st", lat, 3, 16'h0000, 5'b00100, 0);
    run_op(1, 3'd7, 0, 0, 16'h0000, 16'h0001, 3'b001, lat);
    op_chk("undef16", lat, 3, 16'h0001, 5'b00001, 0);
    run_op(0, 3'd0, ALU_OP_ADD, 1, 16'hAB7F, 16'hCD01, 3'b000, lat);
    op_chk("add8", lat, 2, 16'hAB80, 5'b11010, 1);
    run_op(0, 3'd0, ALU_OP_CMP, 1, 16'h0005, 16'h0005, 3'b000, lat);
    op_chk("cmp8", lat, 2, 16'h0000, 5'b00100, 0);

    // Back-to-back: start held high through three ops
    @(negedge clk);
    wide = 1; op16 = ALU16_ADD; a16 = 16'h0001; b16 = 16'h0001; cc_in = 3'b000; start = 1'b1;
    @(posedge clk);
    dmask = '0; bmask = '0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      dmask[i-1] = done;
      bmask[i-1] = busy;
      if (i == 8) start = 1'b0;
    end
    chk("b2b.done_mask", dmask, 9'b100100100);
    chk("b2b.busy_mask", bmask, 9'b011011011);
    chk("b2b.res", result, 16'h0002);
    @(negedge clk);
    chk("b2b.idle_ready", ready, 1);
    chk("b2b.idle_done", done, 0);

    // start while busy must not re-latch operands or queue a second op
    @(negedge clk);
    wide = 1; op16 = ALU16_ADD; a16 = 16'h7FFF; b16 = 16'h0001; cc_in = 3'b000; start = 1'b1;
    @(posedge clk);
    #1 a16 = 16'h5000; b16 = 16'h0700; op16 = ALU16_SUB;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    op_chk("busy_ign", lat, 2, 16'h8000, 5'b01010, 1);
    @(negedge clk);
    chk("busy_ign.no_second_done", done, 0);
    chk("busy_ign.ready", ready, 1);

    // Reset during the high pass
    @(negedge clk);
    wide = 1; op16 = ALU16_ADD; a16 = 16'h12FF; b16 = 16'h0001; cc_in = 3'b000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.ready", ready, 1);
    chk("midrst.done", done, 0);
    chk("midrst.res", result, 0);
    chk("midrst.cc", cc_out, 0);
    chk("midrst.wb", wb, 0);
    dmask = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmask[i] = done;
    end
    chk("midrst.no_done", dmask, 0);
    reset_n = 1'b1;
    run_op(1, ALU16_ADD, 0, 0, 16'h12FF, 16'h0001, 3'b000, lat);
    op_chk("post_rst_add", lat, 3, 16'h1300, 5'b00000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
